// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: formats byte/half/word accesses onto a simple
// req/ack bus, stalls the pipeline while waiting, and retires results with a bounded timeout.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        out_valid,
    output logic        out_reg_write,
    output logic        out_misalign,
    output logic        out_timeout,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;

    logic        out_valid_q, out_valid_d;
    logic        out_reg_write_q, out_reg_write_d;
    logic        out_misalign_q, out_misalign_d;
    logic        out_timeout_q, out_timeout_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;

    logic        is_mem, illegal, misalign;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode of the op sitting in EX/MEM; size comes from funct3[1:0] for both loads and stores.
    always_comb begin
        is_mem   = in_mem_read | in_mem_write;
        illegal  = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0])
                || ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        fmt_wdata = in_wdata;
        fmt_wstrb = 4'b0000;
        case (in_funct3[1:0])
            2'b00:   fmt_wdata = {4{in_wdata[7:0]}};
            2'b01:   fmt_wdata = {2{in_wdata[15:0]}};
            default: fmt_wdata = in_wdata;
        endcase
        if (in_mem_write) begin
            case (in_funct3[1:0])
                2'b00:   fmt_wstrb = 4'b0001 << in_addr[1:0];
                2'b01:   fmt_wstrb = 4'b0011 << in_addr[1:0];
                default: fmt_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'(bus_rdata >> {addr_q[1:0], 3'b000});
        ld_half = 16'(bus_rdata >> {addr_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        rd_d            = rd_q;
        reg_write_d     = reg_write_q;
        out_valid_d     = 1'b0;
        out_reg_write_d = 1'b0;
        out_misalign_d  = 1'b0;
        out_timeout_d   = 1'b0;
        out_rd_d        = out_rd_q;
        out_data_d      = out_data_q;
        stall           = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        out_valid_d     = 1'b1;
                        out_data_d      = in_addr;
                        out_rd_d        = in_rd;
                        out_reg_write_d = in_reg_write;
                    end else if (illegal || misalign) begin
                        out_valid_d    = 1'b1;
                        out_misalign_d = 1'b1;
                        out_rd_d       = in_rd;
                        out_data_d     = 32'd0;
                    end else begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        cnt_d       = 8'd0;
                        addr_d      = in_addr;
                        wdata_d     = fmt_wdata;
                        wstrb_d     = fmt_wstrb;
                        we_d        = in_mem_write;
                        funct3_d    = in_funct3;
                        rd_d        = in_rd;
                        reg_write_d = in_reg_write;
                    end
                end
            end
            BUSY: begin
                // The ack wins over a timeout landing in the same cycle.
                if (bus_ack) begin
                    state_d         = IDLE;
                    out_valid_d     = 1'b1;
                    out_rd_d        = rd_q;
                    out_reg_write_d = reg_write_q && !we_q;
                    out_data_d      = we_q ? 32'd0 : ld_data;
                end else if (cnt_q == LAST_CNT) begin
                    state_d       = IDLE;
                    out_valid_d   = 1'b1;
                    out_timeout_d = 1'b1;
                    out_rd_d      = rd_q;
                    out_data_d    = 32'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            addr_q          <= 32'd0;
            wdata_q         <= 32'd0;
            wstrb_q         <= 4'd0;
            we_q            <= 1'b0;
            funct3_q        <= 3'd0;
            rd_q            <= 5'd0;
            reg_write_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_misalign_q  <= 1'b0;
            out_timeout_q   <= 1'b0;
            out_rd_q        <= 5'd0;
            out_data_q      <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            out_valid_q     <= out_valid_d;
            out_reg_write_q <= out_reg_write_d;
            out_misalign_q  <= out_misalign_d;
            out_timeout_q   <= out_timeout_d;
            out_rd_q        <= out_rd_d;
            out_data_q      <= out_data_d;
        end
    end

    // Bus controls are gated by state so reset drops them without waiting for a clock.
    assign bus_req   = (state_q == BUSY);
    assign bus_we    = (state_q == BUSY) && we_q;
    assign bus_wstrb = (state_q == BUSY) ? wstrb_q : 4'b0000;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;

    assign out_valid     = out_valid_q;
    assign out_reg_write = out_reg_write_q;
    assign out_misalign  = out_misalign_q;
    assign out_timeout   = out_timeout_q;
    assign out_rd        = out_rd_q;
    assign out_data      = out_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: each op's bus activity, stall length and retired result
// are predicted from the access rules with plain arithmetic.
module tb_mem_lsu;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic        out_reg_write;
    logic        out_misalign;
    logic        out_timeout;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    int n_checks;
    int n_pass;
    int n_fail;

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_reg_write(out_reg_write),
        .out_misalign(out_misalign), .out_timeout(out_timeout),
        .out_rd(out_rd), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scrambleInputs();
        in_valid     = 1'($urandom);
        in_mem_read  = 1'($urandom);
        in_mem_write = 1'($urandom);
        in_funct3    = 3'($urandom);
        in_addr      = $urandom;
        in_wdata     = $urandom;
        in_rd        = 5'($urandom);
        in_reg_write = 1'($urandom);
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the retiring edge.
    // ack_at = BUSY cycle (1-based) carrying bus_ack; 0 means the bus never answers.
    task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic rw,
                                 input int ack_at, input logic [31:0] rdata);
        logic        is_mem, bad;
        int          nb, off, stalls, reqs, exp_cycles;
        logic        timed_out, ack_now;
        logic [31:0] exp_wd, v;
        logic [3:0]  exp_ws;
        is_mem = rd_en | wr_en;
        nb     = 1 << f3[1:0];
        off    = int'(addr[1:0]);
        bad    = is_mem && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (off % nb != 0));

        in_valid     = 1'b1;
        in_mem_read  = rd_en;
        in_mem_write = wr_en;
        in_funct3    = f3;
        in_addr      = addr;
        in_wdata     = wdata;
        in_rd        = rd;
        in_reg_write = rw;
        bus_ack      = 1'($urandom);
        bus_rdata    = $urandom;
        #1;
        if (!is_mem || bad) begin
            checkOutput("direct_stall", 32'(stall), 32'd0);
            checkOutput("direct_bus_req", 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            checkOutput("direct_out_valid", 32'(out_valid), 32'd1);
            checkOutput("direct_out_misalign", 32'(out_misalign), 32'(bad));
            checkOutput("direct_out_timeout", 32'(out_timeout), 32'd0);
            if (bad) begin
                checkOutput("misalign_reg_write", 32'(out_reg_write), 32'd0);
            end else begin
                checkOutput("alu_out_data", out_data, addr);
                checkOutput("alu_out_rd", 32'(out_rd), 32'(rd));
                checkOutput("alu_out_reg_write", 32'(out_reg_write), 32'(rw));
            end
        end else begin
            checkOutput("issue_stall", 32'(stall), 32'd1);
            checkOutput("issue_bus_req", 32'(bus_req), 32'd0);
            exp_ws = wr_en ? 4'(((1 << nb) - 1) << off) : 4'd0;
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
            stalls    = 1;
            reqs      = 0;
            timed_out = 1'b1;
            for (int k = 1; k <= TIMEOUT; k++) begin
                @(posedge clk); #1;
                scrambleInputs();
                ack_now   = (k == ack_at);
                bus_ack   = ack_now;
                bus_rdata = ack_now ? rdata : $urandom;
                #1;
                checkOutput("busy_bus_req", 32'(bus_req), 32'd1);
                checkOutput("busy_bus_addr", bus_addr, {addr[31:2], 2'b00});
                checkOutput("busy_bus_we", 32'(bus_we), 32'(wr_en));
                checkOutput("busy_bus_wstrb", 32'(bus_wstrb), 32'(exp_ws));
                if (wr_en) checkOutput("busy_bus_wdata", bus_wdata, exp_wd);
                checkOutput("busy_out_valid", 32'(out_valid), 32'd0);
                checkOutput("busy_stall", 32'(stall), 32'(!ack_now && (k != TIMEOUT)));
                reqs   += int'(bus_req);
                stalls += int'(stall);
                if (ack_now) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            exp_cycles = timed_out ? TIMEOUT : ack_at;
            checkOutput("stall_cycles", 32'(stalls), 32'(exp_cycles));
            checkOutput("bus_req_cycles", 32'(reqs), 32'(exp_cycles));
            checkOutput("retire_out_valid", 32'(out_valid), 32'd1);
            checkOutput("retire_out_misalign", 32'(out_misalign), 32'd0);
            checkOutput("retire_out_timeout", 32'(out_timeout), 32'(timed_out));
            checkOutput("retire_out_rd", 32'(out_rd), 32'(rd));
            checkOutput("retire_out_reg_write", 32'(out_reg_write), 32'(!timed_out && !wr_en && rw));
            if (!timed_out) begin
                v = rdata >> (8 * off);
                if (wr_en) begin
                    v = 32'd0;
                end else if (nb == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                end
                checkOutput("retire_out_data", out_data, v);
            end
        end
    endtask

    task automatic idleCycle();
        scrambleInputs();
        in_valid  = 1'b0;
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
        #1;
        checkOutput("idle_stall", 32'(stall), 32'd0);
        checkOutput("idle_bus_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        bus_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] st_f3 [8];
        int         kind, ack;
        logic [2:0] f3;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd7, 3'd2};
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = 3'd0;
        in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; in_reg_write = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_bus_req", 32'(bus_req), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'd0, 5'd3, 1'b1, 3, 32'h80FF_FF00);
        applyStimulus(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 5'd4, 1'b1, 2, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'd0, 5'd5, 1'b1, 1, 32'd0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 3'd5, 32'h0000_4002, 32'd0, 5'd6, 1'b1, 0, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd7, 1'b1, 0, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_5000, 32'd0, 5'd8, 1'b1, 1, 32'hCAFE_F00D);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h0000_6001, 32'h0000_00A5, 5'd9, 1'b1, 2, 32'd0);

        // Reset in the middle of a store's BUSY phase.
        in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b1; in_funct3 = 3'd2;
        in_addr = 32'h0000_0040; in_wdata = 32'h1357_9BDF; in_rd = 5'd1; in_reg_write = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("pre_reset_bus_req", 32'(bus_req), 32'd1);
        checkOutput("pre_reset_bus_we", 32'(bus_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_bus_req", 32'(bus_req), 32'd0);
        checkOutput("async_reset_bus_we", 32'(bus_we), 32'd0);
        checkOutput("async_reset_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("async_reset_stall", 32'(stall), 32'd0);
        checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd4, 32'h0000_0000, 32'd0, 5'd2, 1'b1, 2, 32'h1234_56F1);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            ack  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            if (kind <= 2) begin
                applyStimulus(1'b0, 1'b0, 3'($urandom), $urandom, $urandom,
                              5'($urandom), 1'($urandom), ack, $urandom);
            end else if (kind <= 5) begin
                f3 = ld_f3[$urandom_range(0, 7)];
                applyStimulus(1'b1, 1'b0, f3, $urandom, $urandom,
                              5'($urandom), 1'($urandom), ack, $urandom);
            end else begin
                f3 = st_f3[$urandom_range(0, 7)];
                applyStimulus(kind == 9, 1'b1, f3, $urandom, $urandom,
                              5'($urandom), 1'($urandom), ack, $urandom);
            end
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
        in_valid = 1'b0;
        idleCycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
